spi_flash_reader: RTL

Parametrised SPI mode-0 master that issues a flash read command (opcode, address, N data bytes) and streams the returned bytes out over a valid/ready handshake. It sits between fabric logic and the ICE_SS/ICE_SCK/ICE_MOSI/ICE_MISO pins. It replaces ad-hoc bit-banged SPI built from free-running dividers. It adds a programmable SCK rate, address width, burst length, byte-level backpressure and clean chip-select framing.

---
 rtl/spi_flash_reader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_reader.sv
// SPI mode-0 flash read master: sends opcode + address, then streams the
// returned bytes out over a valid/ready handshake. SCK is stretched low
// (never high) whenever the output byte has not been taken in time.
module spi_flash_reader #(
    parameter int         CLK_DIV = 8,
    parameter int         ADDR_W  = 24,
    parameter int         LEN_W   = 8,
    parameter logic [7:0] CMD     = 8'h03
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              spi_ss,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(ADDR_W);
    localparam int TX_W  = 8 + ADDR_W;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_W - 1);
    localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DATA, S_STALL, S_CS_HOLD, S_GAP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [DIV_W-1:0]   r_div;         // cycles spent in the current half-cell / phase
    logic               r_phase;       // 0: sck low half, 1: sck high half
    logic [BIT_W-1:0]   r_bit;         // bit index inside CMD, ADDR or the current data byte
    logic [TX_W-1:0]    r_tx;          // {opcode, address}, shifted out MSB first
    logic [7:0]         r_rx;          // byte being assembled from spi_miso
    logic [LEN_W:0]     r_bytes_left;  // data bytes whose 8th sample has not happened yet
    logic               r_land;        // a complete byte moves to rd_data next edge
    logic [7:0]         r_rd_data;
    logic               r_rd_valid;

    logic w_accept;
    logic w_div_end;
    logic w_shifting;
    logic w_rise;
    logic w_cell_end;
    logic w_hs;
    logic w_out_full;
    logic w_more;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_div_end  = (r_div == DIV_LAST);
    assign w_shifting = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_rise     = w_shifting && !r_phase && w_div_end;
    assign w_cell_end = w_shifting && r_phase && w_div_end;
    assign w_hs       = r_rd_valid && rd_ready;
    // The output register counts as occupied if a byte is about to land or
    // the current one is not being taken this cycle.
    assign w_out_full = r_land || (r_rd_valid && !rd_ready);
    assign w_more     = (r_bytes_left != '0);

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decode.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next_state = S_CS_SETUP;
            S_CS_SETUP: if (w_div_end) w_next_state = S_CMD;
            S_CMD:      if (w_cell_end && r_bit == BYTE_LAST) w_next_state = S_ADDR;
            S_ADDR:     if (w_cell_end && r_bit == ADDR_LAST) w_next_state = S_DATA;
            S_DATA: begin
                if (w_cell_end && r_bit == BYTE_LAST) begin
                    if (w_out_full)  w_next_state = S_STALL;
                    else if (w_more) w_next_state = S_DATA;
                    else             w_next_state = S_CS_HOLD;
                end
            end
            S_STALL:    if (w_hs) w_next_state = w_more ? S_DATA : S_CS_HOLD;
            S_CS_HOLD:  if (w_div_end) w_next_state = S_GAP;
            S_GAP:      if (w_div_end) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Pin and status outputs decoded from the current state.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        spi_ss   = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        case (r_state)
            S_CS_SETUP: begin
                busy     = 1'b1;
                spi_ss   = 1'b0;
                spi_mosi = r_tx[TX_W-1];
            end
            S_CMD, S_ADDR: begin
                busy     = 1'b1;
                spi_ss   = 1'b0;
                spi_sck  = r_phase;
                spi_mosi = r_tx[TX_W-1];
            end
            S_DATA: begin
                busy    = 1'b1;
                spi_ss  = 1'b0;
                spi_sck = r_phase;
            end
            S_STALL, S_CS_HOLD: begin
                busy   = 1'b1;
                spi_ss = 1'b0;
            end
            S_GAP:   done = (r_div == '0);
            default: ;
        endcase
    end

    // Bit-cell timing, shift registers, byte counter and output byte register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div        <= '0;
            r_phase      <= 1'b0;
            r_bit        <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_bytes_left <= '0;
            r_land       <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            if (r_state == S_IDLE || r_state == S_STALL ||
                w_next_state != r_state || w_div_end)
                r_div <= '0;
            else
                r_div <= r_div + 1'b1;

            if (!w_shifting)
                r_phase <= 1'b0;
            else if (w_div_end)
                r_phase <= !r_phase;

            if (!w_shifting)
                r_bit <= '0;
            else if (w_cell_end)
                r_bit <= (w_next_state != r_state ||
                          (r_state == S_DATA && r_bit == BYTE_LAST)) ? '0 : r_bit + 1'b1;

            if (w_accept)
                r_tx <= {CMD, addr};
            else if (w_cell_end && r_state != S_DATA)
                r_tx <= {r_tx[TX_W-2:0], 1'b0};

            if (w_accept)
                r_bytes_left <= {1'b0, len} + 1'b1;
            else if (w_rise && r_state == S_DATA && r_bit == BYTE_LAST)
                r_bytes_left <= r_bytes_left - 1'b1;

            if (w_rise && r_state == S_DATA)
                r_rx <= {r_rx[6:0], spi_miso};

            r_land <= w_rise && (r_state == S_DATA) && (r_bit == BYTE_LAST);

            if (r_land) begin
                r_rd_data  <= r_rx;
                r_rd_valid <= 1'b1;
            end else if (w_hs) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule
